// File: rtl/seq_mult4x4.sv
// Sequential 4x4 unsigned shift-and-add multiplier: one 4-bit ripple-carry add per cycle,
// the carry-out and sum shifted into an 8-bit {acc,q} accumulator. Four steps per product.
module seq_mult4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | four add/shift steps in progress
  // DONE  | product valid, one-cycle done pulse; start here chains the next multiply
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] q_q, q_d;
  logic [1:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] product_q, product_d;

  logic [3:0] sum_s;
  logic       cout_s;
  logic [7:0] step_s;

  // Ripple-carry add of acc and the (gated) multiplicand; carry kept local to the block.
  always_comb begin
    logic [3:0] addend;
    logic       c;
    addend = q_q[0] ? m_q : 4'd0;
    c      = 1'b0;
    sum_s  = 4'd0;
    for (int i = 0; i < 4; i++) begin
      sum_s[i] = acc_q[i] ^ addend[i] ^ c;
      c        = (acc_q[i] & addend[i]) | (c & (acc_q[i] ^ addend[i]));
    end
    cout_s = c;
  end

  assign step_s = {cout_s, sum_s, q_q[3:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = 4'd0;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_s[7:4];
        q_d   = step_s[3:0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d   = DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = step_s;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= 4'd0;
      acc_q     <= 4'd0;
      q_q       <= 4'd0;
      cnt_q     <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult4x4.sv
// Scoreboard bench for seq_mult4x4: stimulus pushes expected products, a negedge monitor
// pops and compares on every done pulse; directed timing checks run alongside.
module tb_seq_mult4x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  seq_mult4x4 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("product", {24'd0, product}, {24'd0, e});
        end
      end
    end
  end

  // Single op from IDLE with full timing checks; returns #1 after E5 with DUT idle.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] ev);
    @(posedge clk); #1;
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(ev);
    @(posedge clk); #1;              // E0
    start = 1'b0;
    a = 4'hx; b = 4'hx;
    for (int i = 1; i <= 3; i++) begin
      chk("busy_run", {30'd0, busy, done}, 32'd2);
      @(posedge clk); #1;            // E1..E3
    end
    chk("busy_run", {30'd0, busy, done}, 32'd2);
    @(posedge clk); #1;              // E4
    chk("done_e4", {30'd0, busy, done}, 32'd1);
    chk("product_e4", {24'd0, product}, {24'd0, ev});
    @(posedge clk); #1;              // E5
    chk("done_e5", {30'd0, busy, done}, 32'd0);
    chk("product_held", {24'd0, product}, {24'd0, ev});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    #12;
    chk("reset_outputs", {22'd0, busy, done, product}, 32'd0);
    rst = 1'b0;

    run_op(4'd9, 4'd11, 8'h63);
    repeat (3) @(posedge clk);
    #1 chk("basic_hold", {24'd0, product}, 32'h63);

    run_op(4'd15, 4'd15, 8'hE1);
    run_op(4'd0, 4'd9, 8'h00);
    run_op(4'd7, 4'd0, 8'h00);
    run_op(4'd1, 4'd15, 8'h0F);

    // Ignored start: second request lands at E2 while busy.
    @(posedge clk); #1;
    a = 4'd3; b = 4'd5; start = 1'b1;
    exp_q.push_back(8'h0F);
    @(posedge clk); #1;              // E0
    start = 1'b0;
    @(posedge clk); #1;              // E1
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1;              // E2
    start = 1'b0;
    chk("ignored_busy_e2", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;              // E3
    chk("ignored_busy_e3", {30'd0, busy, done}, 32'd2);
    @(posedge clk); #1;              // E4
    chk("ignored_done_e4", {30'd0, busy, done}, 32'd1);
    chk("ignored_product", {24'd0, product}, 32'h0F);
    @(posedge clk); #1;

    // Back-to-back: start held through DONE.
    a = 4'd6; b = 4'd7; start = 1'b1;
    exp_q.push_back(8'h2A);
    @(posedge clk); #1;              // E0
    a = 4'd12; b = 4'd13;
    exp_q.push_back(8'h9C);
    repeat (4) @(posedge clk);
    #1;                              // E4
    chk("b2b_done1", {30'd0, busy, done}, 32'd1);
    chk("b2b_product1", {24'd0, product}, 32'h2A);
    @(posedge clk); #1;              // E5
    start = 1'b0;
    chk("b2b_accept2", {30'd0, busy, done}, 32'd2);
    chk("b2b_old_product", {24'd0, product}, 32'h2A);
    repeat (3) @(posedge clk);
    #1;                              // E8
    chk("b2b_old_product_e8", {24'd0, product}, 32'h2A);
    @(posedge clk); #1;              // E9
    chk("b2b_done2", {30'd0, busy, done}, 32'd1);
    chk("b2b_product2", {24'd0, product}, 32'h9C);
    @(posedge clk); #1;

    // Reset mid-run between E2 and E3, asserted away from any edge.
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(posedge clk); #1;              // E0
    start = 1'b0;
    repeat (2) @(posedge clk);       // E2
    #3 rst = 1'b1;
    #1 chk("async_reset", {22'd0, busy, done, product}, 32'd0);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("abort_no_done", {30'd0, busy, done}, 32'd0);
    run_op(4'd2, 4'd3, 8'h06);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = i[7:0];
      a = idx[7:4]; b = idx[3:0]; start = 1'b1;
      exp_q.push_back(8'(idx[7:4] * idx[3:0]));
      @(posedge clk); #1;            // accept
      a = 4'hx; b = 4'hx;
      repeat (4) @(posedge clk);
      #1;                            // DONE cycle
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
